// File: rtl/dff_bank_arbiter_pkg.sv
// rtl/dff_bank_arbiter_pkg.sv - shared types and arbitration helpers for dff_bank_arbiter
package dff_bank_arbiter_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Result of a round-robin scan: found flag plus winner index.
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // One-hot vector with bit idx set, restricted to the low n bits.
    function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int n);
        logic [MAX_NREQ-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (i < n && i == idx) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // First requester at or after ptr, scanning cyclically over n requesters.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req, input int ptr, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < n) begin
                j = (ptr + k) % n;
                if (!p.found && req[j]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_dff_reg.sv
// rtl/dff_bank_arbiter_dff_reg.sv - shared storage register with load enable
module dff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset, capture d only on granted cycles, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin burst arbiter sharing one flop bank
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         q,
    output logic                     valid,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("dff_bank_arbiter: NREQ must be in 2..8");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("dff_bank_arbiter: MAX_BURST must be >= 1");
    end

    state_t              state;
    state_t              state_next;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       cur;
    logic [CW-1:0]       cnt;
    logic [MAX_NREQ-1:0] req_ext;
    pick_t               pick;
    logic                grant;
    logic                take_new;
    logic [IW-1:0]       win;
    logic [WIDTH-1:0]    sel_data;

    // Decide who owns this cycle: continue the burst, hand off, or go idle.
    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        pick                = rr_pick(req_ext, int'(ptr), NREQ);
        grant               = 1'b0;
        take_new            = 1'b0;
        win                 = cur;
        state_next          = state;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    grant      = 1'b1;
                    take_new   = 1'b1;
                    win        = IW'(pick.idx);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (req[cur] && cnt < CW'(MAX_BURST)) begin
                    grant = 1'b1;
                end else if (pick.found) begin
                    // ptr already sits at cur+1, so cur is scanned last.
                    grant    = 1'b1;
                    take_new = 1'b1;
                    win      = IW'(pick.idx);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            grant      = 1'b0;
            take_new   = 1'b0;
            state_next = IDLE;
        end
        gnt = grant ? NREQ'(onehot(int'(win), NREQ)) : '0;
    end

    // Route the winner's data slice to the storage register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ownership, burst counter, rotation pointer and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cur   <= '0;
            cnt   <= '0;
            owner <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner <= win;
                valid <= 1'b1;
                if (take_new) begin
                    cur <= win;
                    cnt <= CW'(1);
                    ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    dff_reg #(
        .WIDTH(WIDTH)
    ) u_dff_reg (
        .clk  (clk),
        .rst  (rst),
        .load (|gnt),
        .d    (sel_data),
        .q    (q)
    );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           valid;
    logic [1:0]     owner;

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers.
    int             m_busy, m_cur, m_cnt, m_ptr, m_owner;
    logic [W-1:0]   m_q;
    logic           m_valid;
    logic [N-1:0]   last_gnt;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .valid (valid),
        .owner (owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check grant, clock, check stored state.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
        int  w;
        bit  cont;
        logic [N-1:0] eg;
        rst   = r;
        req   = rq;
        wdata = wd;
        #2;
        w    = -1;
        cont = 0;
        if (!r) begin
            if (m_busy != 0 && rq[m_cur] && m_cnt < MB) begin
                w    = m_cur;
                cont = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        last_gnt = gnt;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        #1;
        if (r) begin
            m_busy = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
            m_q = '0; m_valid = 1'b0; m_owner = 0;
        end else if (w >= 0) begin
            if (cont) begin
                m_cnt++;
            end else begin
                m_busy = 1; m_cur = w; m_cnt = 1; m_ptr = (w + 1) % N;
            end
            m_q     = wd[w*W +: W];
            m_valid = 1'b1;
            m_owner = w;
        end else begin
            m_busy = 0;
        end
        chk("q", 32'(q), 32'(m_q));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("owner", 32'(owner), 32'(m_owner));
    endtask

    initial begin
        logic [3:0] burst_exp [7];
        rst = 1'b1; req = '0; wdata = '0;
        m_busy = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
        m_q = '0; m_valid = 1'b0; m_owner = 0;
        last_gnt = '0;
        @(posedge clk);
        #1;

        // Reset with all requesting
        cyc(1'b1, 4'b1111, 32'h44332211);
        cyc(1'b1, 4'b1111, 32'h44332211);
        chk("rst_gnt", 32'(last_gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        cyc(1'b0, 4'b1111, 32'h44332211);
        chk("first_gnt", 32'(last_gnt), 32'h1);

        // Single requester re-wins after exhausting its burst
        cyc(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b0100, 32'h00A50000);
            chk("single_gnt", 32'(last_gnt), 32'h4);
            if (i == 0) begin
                chk("single_q", 32'(q), 32'hA5);
                chk("single_owner", 32'(owner), 32'h2);
                chk("single_valid", 32'(valid), 32'h1);
            end
        end

        // Burst limit forces rotation
        burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        cyc(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 4'b0011, 32'h00002211);
            chk("burst_gnt", 32'(last_gnt), 32'(burst_exp[i]));
            chk("burst_q", 32'(q), (i >= 3 && i <= 5) ? 32'h22 : 32'h11);
        end

        // Early release hands off with no bubble, then wrap to requester 0
        cyc(1'b1, 4'b0000, 32'h0);
        cyc(1'b0, 4'b1001, 32'h33000011);
        chk("early_gnt0", 32'(last_gnt), 32'h1);
        cyc(1'b0, 4'b1000, 32'h33000011);
        chk("early_gnt3", 32'(last_gnt), 32'h8);
        chk("early_owner", 32'(owner), 32'h3);
        cyc(1'b0, 4'b1000, 32'h33000011);
        cyc(1'b0, 4'b1000, 32'h33000011);
        cyc(1'b0, 4'b1001, 32'h33000011);
        chk("wrap_gnt", 32'(last_gnt), 32'h1);

        // Idle hold, then reset mid-burst
        cyc(1'b1, 4'b0000, 32'h0);
        cyc(1'b0, 4'b0001, 32'h0000005A);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b0000, 32'hFFFFFFFF);
            chk("idle_gnt", 32'(last_gnt), 32'h0);
            chk("idle_q", 32'(q), 32'h5A);
            chk("idle_valid", 32'(valid), 32'h1);
        end
        cyc(1'b0, 4'b0100, 32'h00770000);
        cyc(1'b0, 4'b0100, 32'h00770000);
        cyc(1'b1, 4'b0100, 32'h00770000);
        chk("midrst_q", 32'(q), 32'h0);
        cyc(1'b0, 4'b0110, 32'h00776600);
        chk("midrst_gnt", 32'(last_gnt), 32'h2);

        // Randomized traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
